// File: rtl/dff_pipe_pkg.sv
// Shared types and helpers for the dff_pipe elastic pipeline register.
// Optional synchronous flush is enabled by defining DFF_PIPE_FLUSH_EN.
package dff_pipe_pkg;

  localparam int DFF_PIPE_MAX_DEPTH = 16;

  // Payload width of the router flit carried by flit_stage_t.
  localparam int FLIT_W = 32;

  typedef struct packed {
    logic              valid;
    logic [FLIT_W-1:0] data;
  } flit_stage_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid+data register of the elastic pipe. Data only moves when a real
// beat arrives, so bubbles never toggle the payload flops.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= valid_d;
    end
  end

  // Clear drops the beat but leaves the payload where it is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (load && valid_d && !clear) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage pipeline register with bubble-collapsing ready chain
// and registered occupancy. Define DFF_PIPE_FLUSH_EN to add the flush port.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic                      flush,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int               OW      = cnt_w(DEPTH);
  localparam logic [OW-1:0]    OCC_ONE = OW'(1);

  if (DEPTH < 1 || DEPTH > DFF_PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("dff_pipe: DEPTH out of range");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("dff_pipe: WIDTH must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             flush_i;
  logic             in_fire;
  logic             out_fire;
  logic [OW-1:0]    occ;

`ifdef DFF_PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready may depend on valid
  // further down the chain (out_ready ripples back to in_ready).
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;

    if (i == 0) begin : g_head
      assign vin = in_valid;
      assign din = in_data;
    end else begin : g_body
      assign vin = v[i-1];
      assign din = d[i-1];
    end

    assign rdy[i] = ~v[i] | rdy[i+1];

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush_i),
      .load    (rdy[i]),
      .valid_d (vin),
      .data_d  (din),
      .valid_q (v[i]),
      .data_q  (d[i])
    );
  end

  assign in_ready  = rdy[0] & ~flush_i;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (flush_i) begin
      occ <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  assign occupancy = occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5) with an
// expected-queue scoreboard; covers flush when DFF_PIPE_FLUSH_EN is defined.
module tb_dff_pipe;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RVAL  = 8'hA5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef DFF_PIPE_FLUSH_EN
  logic             flush;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RVAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DFF_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Clock and global time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver: called at posedge+1, presents a beat, records it if accepted,
  // and returns at the next posedge+1.
  task automatic cycle_in(input logic vld, input logic [WIDTH-1:0] dat);
    in_valid = vld;
    in_data  = dat;
    #2;
    if (vld && in_ready) exp_q.push_back(dat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_in(1'b0, 8'h00);
  endtask

  // Monitor: pops the scoreboard on every output transfer
  always @(negedge clk) begin
    if (!reset) begin
      check("occ_popcount", 32'(occupancy), 32'($countones(dut.v)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("out_data_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
    flush     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_d2", 32'(dut.d[2]), 32'hA5);
    reset = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle_in(1'b1, 8'(k));
      check("stream_occ", 32'(occupancy), (k < 3) ? 32'(k) : 32'd3);
      check("stream_out_valid", 32'(out_valid), (k < 3) ? 32'd0 : 32'd1);
      if (k >= 3) check("stream_out_data", 32'(out_data), 32'(k - 2));
    end
    idle(4);
    check("stream_drain_occ", 32'(occupancy), 32'd0);
    check("stream_drain_q", 32'(exp_q.size()), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    cycle_in(1'b1, 8'h11);
    cycle_in(1'b1, 8'h22);
    cycle_in(1'b1, 8'h33);
    check("bp_occ_full", 32'(occupancy), 32'd3);
    in_valid = 1'b1;
    in_data  = 8'h44;
    #1;
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("bp_stall_data", 32'(out_data), 32'h11);
    check("bp_stall_valid", 32'(out_valid), 32'd1);
    check("bp_stall_occ", 32'(occupancy), 32'd3);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_passthru", 32'(in_ready), 32'd1);
    cycle_in(1'b1, 8'h44);
    check("bp_swap_occ", 32'(occupancy), 32'd3);
    check("bp_swap_data", 32'(out_data), 32'h22);
    idle(4);
    check("bp_drain_q", 32'(exp_q.size()), 32'd0);

    // Bubble collapse
    out_ready = 1'b0;
    cycle_in(1'b1, 8'h55);
    idle(2);
    cycle_in(1'b1, 8'h66);
    idle(1);
    check("bub_v", 32'(dut.v), 32'b110);
    check("bub_d1", 32'(dut.d[1]), 32'h66);
    check("bub_out_data", 32'(out_data), 32'h55);
    check("bub_occ", 32'(occupancy), 32'd2);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_d2", 32'(dut.d[2]), 32'hA5);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    cycle_in(1'b1, 8'h77);
    check("arst_lat1", 32'(out_valid), 32'd0);
    idle(1);
    check("arst_lat2", 32'(out_valid), 32'd0);
    idle(1);
    check("arst_lat3_valid", 32'(out_valid), 32'd1);
    check("arst_lat3_data", 32'(out_data), 32'h77);
    idle(2);
    check("arst_drain_q", 32'(exp_q.size()), 32'd0);

`ifdef DFF_PIPE_FLUSH_EN
    // Flush while full with a beat presented
    out_ready = 1'b0;
    cycle_in(1'b1, 8'h81);
    cycle_in(1'b1, 8'h82);
    cycle_in(1'b1, 8'h83);
    check("fl_occ_full", 32'(occupancy), 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    out_ready = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    // 0x81 left during the flush cycle and was consumed by the monitor
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_data_kept", 32'(out_data), 32'h81);
    exp_q.delete();
    out_ready = 1'b1;
    cycle_in(1'b1, 8'h9A);
    idle(4);
    check("fl_after_q", 32'(exp_q.size()), 32'd0);
`endif

    check("final_occ", 32'(occupancy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
